// File: rtl/a5_stream_cipher.sv
// A5/1-style keystream generator feeding a valid/ready XOR datapath (plaintext in, ciphertext out).
// Build option A5_FN_AUTOINC_EN: at frame end rekey with the latched key and fn+1 instead of idling.
module a5_stream_cipher #(
    parameter int DW          = 8,
    parameter int FRAME_WORDS = 32,
    parameter int WARMUP      = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [63:0]   i_key,
    input  logic [21:0]   i_fn,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic [2:0]    o_state
);

    localparam int ACW = (DW > 1) ? $clog2(DW) : 1;
    localparam int WCW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_FN  = 3'd2,
        S_WARMUP   = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_cnt;
    logic [85:0]      r_load_sh;
    logic [18:0]      r_r1;
    logic [21:0]      r_r2;
    logic [22:0]      r_r3;
    logic [DW-1:0]    r_acc;
    logic [ACW-1:0]   r_acc_cnt;
    logic [DW-1:0]    r_ks_word;
    logic             r_ks_full;
    logic [WCW-1:0]   r_word_cnt;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic             r_frame_done;

    logic             w_start_go;
    logic             w_loading;
    logic             w_in_bit;
    logic             w_maj;
    logic             w_maj_phase;
    logic             w_clk1;
    logic             w_clk2;
    logic             w_clk3;
    logic [18:0]      w_r1_nxt;
    logic [21:0]      w_r2_nxt;
    logic [22:0]      w_r3_nxt;
    logic             w_ks_bit;
    logic [DW-1:0]    w_acc_shift;
    logic             w_acc_last;
    logic             w_step;
    logic             w_in_ready;
    logic             w_in_hs;
    logic             w_frame_end;

    // Both ports use valid/ready: a word transfers on a rising edge where valid && ready are high;
    // the producer holds valid and data stable until that edge.
    assign w_start_go  = (r_state == S_IDLE) && i_start;
    assign w_in_ready  = (r_state == S_RUN) && r_ks_full && (!r_out_valid || i_out_ready);
    assign w_in_hs     = i_in_valid && w_in_ready;
    assign w_frame_end = w_in_hs && (r_word_cnt == WCW'(FRAME_WORDS - 1));
    assign w_acc_last  = (r_acc_cnt == ACW'(DW - 1));
    // Generation pauses only when the finished word would have nowhere to go.
    assign w_step      = (r_state == S_RUN) && !(r_ks_full && w_acc_last && !w_in_hs);

    assign w_loading   = (r_state == S_LOAD_KEY) || (r_state == S_LOAD_FN);
    assign w_in_bit    = w_loading && r_load_sh[85];
    assign w_maj       = (r_r1[10] & r_r2[11]) | (r_r1[10] & r_r3[12]) | (r_r2[11] & r_r3[12]);
    assign w_maj_phase = (r_state == S_WARMUP) || w_step;
    assign w_clk1      = w_loading || (w_maj_phase && (r_r1[10] == w_maj));
    assign w_clk2      = w_loading || (w_maj_phase && (r_r2[11] == w_maj));
    assign w_clk3      = w_loading || (w_maj_phase && (r_r3[12] == w_maj));

    assign w_r1_nxt = w_clk1 ? {r_r1[5] ^ r_r1[2] ^ r_r1[1] ^ r_r1[0] ^ w_in_bit, r_r1[18:1]} : r_r1;
    assign w_r2_nxt = w_clk2 ? {r_r2[1] ^ r_r2[0] ^ w_in_bit, r_r2[21:1]} : r_r2;
    assign w_r3_nxt = w_clk3 ? {r_r3[15] ^ r_r3[2] ^ r_r3[1] ^ r_r3[0] ^ w_in_bit, r_r3[22:1]} : r_r3;

    assign w_ks_bit    = w_r1_nxt[0] ^ w_r2_nxt[0] ^ w_r3_nxt[0];
    assign w_acc_shift = (r_acc << 1) | DW'(w_ks_bit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_state_nxt = S_LOAD_KEY;
            S_LOAD_KEY: if (r_cnt == 16'd63) w_state_nxt = S_LOAD_FN;
            S_LOAD_FN:  if (r_cnt == 16'd21) w_state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
            S_WARMUP:   if (r_cnt == 16'(WARMUP - 1)) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_frame_end) begin
`ifdef A5_FN_AUTOINC_EN
                    w_state_nxt = S_LOAD_KEY;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_RUN))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
        end
    end

`ifdef A5_FN_AUTOINC_EN
    logic [63:0] r_key;
    logic [21:0] r_fn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_fn  <= '0;
        end else if (w_start_go) begin
            r_key <= i_key;
            r_fn  <= i_fn;
        end else if (w_frame_end) begin
            r_fn  <= r_fn + 22'd1;
        end
    end
`endif

    // Key and frame number are consumed MSB first from one shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_load_sh <= '0;
        else if (w_start_go)
            r_load_sh <= {i_key, i_fn};
`ifdef A5_FN_AUTOINC_EN
        else if (w_frame_end)
            r_load_sh <= {r_key, r_fn + 22'd1};
`endif
        else if (w_loading)
            r_load_sh <= r_load_sh << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1       <= '0;
            r_r2       <= '0;
            r_r3       <= '0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_ks_word  <= '0;
            r_ks_full  <= 1'b0;
            r_word_cnt <= '0;
        end else if (w_start_go || w_frame_end) begin
            r_r1       <= '0;
            r_r2       <= '0;
            r_r3       <= '0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_ks_full  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_r1 <= w_r1_nxt;
            r_r2 <= w_r2_nxt;
            r_r3 <= w_r3_nxt;
            if (w_step && w_acc_last) begin
                r_ks_word <= w_acc_shift;
                r_acc     <= '0;
                r_acc_cnt <= '0;
                r_ks_full <= 1'b1;
            end else begin
                if (w_step) begin
                    r_acc     <= w_acc_shift;
                    r_acc_cnt <= r_acc_cnt + ACW'(1);
                end
                if (w_in_hs)
                    r_ks_full <= 1'b0;
            end
            if (w_in_hs)
                r_word_cnt <= r_word_cnt + WCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_out_data  <= i_in_data ^ r_ks_word;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_frame_done <= w_frame_end;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_a5_stream_cipher.sv
// Bench for a5_stream_cipher: DW=8 and DW=32 instances checked against an A5/1 keystream model.
// Honours A5_FN_AUTOINC_EN when defined (expects rekey with fn+1 after each frame).
module tb_a5_stream_cipher;

    localparam int DW   = 8;
    localparam int FW   = 32;
    localparam int WU   = 100;
    localparam int DW32 = 32;
    localparam int FW32 = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [63:0]   key       = '0;
    logic [21:0]   fn        = '0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          frame_done;
    logic [2:0]    state;

    logic            b_start     = 1'b0;
    logic [63:0]     b_key       = '0;
    logic [21:0]     b_fn        = '0;
    logic            b_in_valid  = 1'b0;
    logic [DW32-1:0] b_in_data   = '0;
    logic            b_out_ready = 1'b1;
    logic            b_in_ready;
    logic            b_out_valid;
    logic [DW32-1:0] b_out_data;
    logic            b_busy;
    logic            b_frame_done;
    logic [2:0]      b_state;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0]   mdl_q[$];
    logic [DW-1:0] exp_q[$];
    int            hs_cnt     = 0;
    bit            exp_fd     = 1'b0;
    bit            last_stall = 1'b0;
    logic [DW-1:0] last_out   = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    a5_stream_cipher #(.DW(DW), .FRAME_WORDS(FW), .WARMUP(WU)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_key(key), .i_fn(fn),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_busy(busy), .o_frame_done(frame_done), .o_state(state)
    );

    a5_stream_cipher #(.DW(DW32), .FRAME_WORDS(FW32), .WARMUP(WU)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_key(b_key), .i_fn(b_fn),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_busy(b_busy), .o_frame_done(b_frame_done), .o_state(b_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] lfsr_step(input logic [63:0] v, input logic [63:0] tap,
                                              input int len, input logic b);
        logic fb;
        fb = (^(v & tap)) ^ b;
        return (v >> 1) | (64'(fb) << (len - 1));
    endfunction

    // Appends nwords keystream words of width dw to mdl_q.
    function automatic void model_gen(input logic [63:0] k, input logic [21:0] f,
                                      input int dw, input int nwords);
        logic [63:0] r[3];
        logic [63:0] tap[3];
        int          len[3];
        int          cb[3];
        logic [63:0] word;
        logic        b;
        logic        m;
        int          ones;
        int          bits;
        len[0] = 19;       len[1] = 22;      len[2] = 23;
        cb[0]  = 10;       cb[1]  = 11;      cb[2]  = 12;
        tap[0] = 64'h27;   tap[1] = 64'h3;   tap[2] = 64'h8007;
        for (int j = 0; j < 3; j++) r[j] = '0;
        for (int i = 0; i < 86; i++) begin
            b = (i < 64) ? k[63 - i] : f[85 - i];
            for (int j = 0; j < 3; j++) r[j] = lfsr_step(r[j], tap[j], len[j], b);
        end
        word = '0;
        bits = 0;
        for (int s = 0; s < WU + nwords * dw; s++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) ones += int'(r[j][cb[j]]);
            m = (ones >= 2);
            for (int j = 0; j < 3; j++)
                if (r[j][cb[j]] == m) r[j] = lfsr_step(r[j], tap[j], len[j], 1'b0);
            if (s >= WU) begin
                word = (word << 1) | 64'(r[0][0] ^ r[1][0] ^ r[2][0]);
                bits++;
                if (bits == dw) begin
                    mdl_q.push_back(word);
                    word = '0;
                    bits = 0;
                end
            end
        end
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [63:0] ksw;
        if (rst_n) begin
            if (last_stall) begin
                check("out_hold_valid", out_valid, 1);
                check("out_stable", out_data, last_out);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_unexpected: got %0h with nothing expected at %0t", out_data, $time);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (!out_ready) check("in_ready_blocked", in_ready, 0);
            end
            check("frame_done", frame_done, exp_fd);
            if (frame_done) begin
`ifdef A5_FN_AUTOINC_EN
                check("busy_at_frame_end", busy, 1);
`else
                check("busy_at_frame_end", busy, 0);
`endif
            end
            exp_fd = 1'b0;
            if (in_valid && in_ready) begin
                if (mdl_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL in_unexpected: handshake with no model word at %0t", $time);
                end else begin
                    ksw = mdl_q.pop_front();
                    exp_q.push_back(in_data ^ ksw[DW-1:0]);
                end
                hs_cnt++;
                if (hs_cnt == FW) begin
                    hs_cnt = 0;
                    exp_fd = 1'b1;
                end
            end
            last_stall = out_valid && !out_ready;
            last_out   = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        b_start = 1'b0; b_in_valid = 1'b0;
        exp_q.delete();
        mdl_q.delete();
        hs_cnt = 0; exp_fd = 1'b0; last_stall = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy32", b_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [63:0] k, input logic [21:0] f,
                               input int nframes, input bit wait_ready);
        int n;
        mdl_q.delete();
        for (int fr = 0; fr < nframes; fr++) model_gen(k, 22'(f + 22'(fr)), DW, FW);
        start = 1'b1; key = k; fn = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wait_ready) begin
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 600) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            check("first_in_ready_edge", n, 186 + DW);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_words(input int n, input int mode);
        int t;
        for (int w = 0; w < n; w++) begin
            case (mode)
                0:       in_data = 8'hA5;
                1:       in_data = DW'(w * 29 + 7);
                default: in_data = DW'($urandom_range(0, 255));
            endcase
            in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 3000);
            if (t >= 3000) begin
                n_vec++;
                n_err++;
                $display("FAIL in_ready_timeout: word %0d not accepted within %0d cycles", w, t);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_remaining", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [63:0] k, input logic [21:0] f);
        int n;
        int t;
        logic [31:0] d;
        logic [63:0] ksw;
        mdl_q.delete();
        model_gen(k, f, DW32, FW32);
        b_key = k; b_fn = f; b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("dw32_first_in_ready_edge", n, 186 + DW32);
        @(posedge clk);
        #1;
        for (int w = 0; w < FW32; w++) begin
            d = 32'h600D_F00D ^ 32'(w * 32'h0101_0101);
            b_in_data = d;
            b_in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!b_in_ready && t < 1000);
            check("dw32_in_ready_seen", b_in_ready, 1);
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            ksw = mdl_q.pop_front();
            @(negedge clk);
            check("dw32_out_valid", b_out_valid, 1);
            check("dw32_out_data", b_out_data, d ^ ksw[31:0]);
            check("dw32_frame_done", b_frame_done, (w == FW32 - 1));
            @(posedge clk);
            #1;
        end
`ifndef A5_FN_AUTOINC_EN
        check("dw32_idle_after_frame", b_busy, 0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();

        // Zero key and fn: the keystream is all zeros, so ciphertext equals plaintext.
        start_frame(64'h0, 22'h0, 1, 1'b1);
        for (int i = 0; i < FW; i++) check("model_zero_ks", mdl_q[i], 64'h0);
        send_words(FW, 0);
        wait_drain();
        check("zero_key_last_out", out_data, 64'hA5);
`ifndef A5_FN_AUTOINC_EN
        check("idle_after_frame", busy, 0);
        check("no_in_ready_in_idle", in_ready, 0);
`endif
        do_reset();

        // Non-trivial key with a 50-cycle output stall mid-frame.
        start_frame(64'h0123_4567_89AB_CDEF, 22'h00134, 1, 1'b1);
        fork
            send_words(FW, 1);
            begin
                repeat (100) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (50) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        do_reset();

        // Start pulsed while running must not disturb the keystream.
        start_frame(64'hFEDC_BA98_7654_3210, 22'h2A5A5, 1, 1'b1);
        send_words(5, 1);
        start = 1'b1;
        key = 64'h1111_2222_3333_4444;
        fn = 22'h00001;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        send_words(FW - 5, 1);
        wait_drain();
        do_reset();

        // Reset during warm-up, then a fresh frame.
        start_frame(64'h5555_AAAA_0F0F_F0F0, 22'h15555, 1, 1'b0);
        repeat (120) @(posedge clk);
        #1;
        check("busy_in_warmup", busy, 1);
        do_reset();
        start_frame(64'h1F2E_3D4C_5B6A_7988, 22'h3C0F0, 1, 1'b1);
        send_words(FW, 2);
        wait_drain();
        do_reset();

`ifdef A5_FN_AUTOINC_EN
        // fn wraps from all-ones to zero for the second frame.
        start_frame(64'hC0FF_EE00_1234_ABCD, 22'h3FFFFF, 2, 1'b1);
        send_words(2 * FW, 1);
        wait_drain();
        do_reset();
`endif

        run32(64'h0BAD_CAFE_DEAD_BEEF, 22'h0ABCD);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/a5_stream_cipher.md
A5_STREAM_CIPHER -- requirements
Module: a5_stream_cipher

Interface
REQ-001 Parameter DW, default 8, is the data/keystream word width in bits (1..64).
REQ-002 Parameter FRAME_WORDS, default 32, is the number of words per frame (>=1).
REQ-003 Parameter WARMUP, default 100, is the number of discarded majority-clock cycles.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  level sampled in IDLE only; latches key and fn, begins keying.
REQ-008 key  in  64  session key, loaded MSB first.
REQ-009 fn  in  22  frame number, loaded MSB first.
REQ-010 in_valid / in_ready  in / out  1 / 1  plaintext handshake.
REQ-011 in_data  in  DW  plaintext word.
REQ-012 out_valid / out_ready  out / in  1 / 1  ciphertext handshake.
REQ-013 out_data  out  DW  ciphertext word.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse on the edge accepting a frame's last word.

Function
REQ-016 LFSRs SHALL be R1[18:0], R2[21:0] and R3[22:0], each shifting right with feedback inserted at the MSB.
REQ-017 Feedback SHALL be: R1 = R1[5]^R1[2]^R1[1]^R1[0]; R2 = R2[1]^R2[0]; R3 = R3[15]^R3[2]^R3[1]^R3[0].
REQ-018 States SHALL be IDLE, LOAD_KEY (64 cycles), LOAD_FN (22), WARMUP (WARMUP), RUN.
REQ-019 On the start edge, all LFSRs SHALL clear, key/fn SHALL latch internally, and the state SHALL become LOAD_KEY.
REQ-020 In LOAD_KEY and LOAD_FN, all three LFSRs SHALL clock every cycle, with the next latched bit (MSB first) XORed into each feedback.
REQ-021 In WARMUP and RUN, clocking SHALL be by majority: m = maj(R1[10], R2[11], R3[12]), and only registers whose clock bit equals m step.
REQ-022 In RUN, each step SHALL produce ks = R1[0]^R2[0]^R3[0] (after stepping), shifted into a DW-bit accumulator with the first bit landing in the MSB.
REQ-023 When DW bits are accumulated, the word SHALL move into a one-word keystream buffer (ks_full=1); generation SHALL stall while ks_full=1 and the accumulator is full.
REQ-024 in_ready SHALL equal ks_full && (!out_valid || out_ready); in_ready SHALL be 0 outside RUN.
REQ-025 On an in handshake, out_data SHALL be in_data ^ ks_word, out_valid SHALL be set, and ks_full SHALL clear, all on the same edge.
REQ-026 out_valid SHALL stay high with out_data stable until out_ready; simultaneous drain and accept SHALL be lossless.
REQ-027 With DW=8, in_ready SHALL first be high in the cycle after edge 186+DW counted from the start-sampling edge (edge 0), with no stalls.
REQ-028 A word counter SHALL count in handshakes; after FRAME_WORDS handshakes, frame_done SHALL pulse and the counter SHALL clear.
REQ-029 start SHALL be ignored while busy.

Reset
REQ-030 On rst_n low: state=IDLE; LFSRs, accumulator, buffer and counters cleared; out_valid=0, out_data=0, in_ready=0, busy=0, frame_done=0.
REQ-031 Reset mid-operation SHALL abort immediately; any pending out word SHALL be discarded.

Configuration
REQ-032 Macro A5_FN_AUTOINC_EN defined: at frame end, fn_reg SHALL be set to fn_reg+1 mod 2^22, the LFSRs SHALL clear, the state SHALL return to LOAD_KEY using the latched key, and busy SHALL stay high.
REQ-033 Macro A5_FN_AUTOINC_EN undefined: at frame end, the state SHALL return to IDLE and busy SHALL drop on the next edge; a new start is required.
REQ-034 In both cases, an out word already in flight SHALL still drain via out_valid/out_ready.

Verification
REQ-035 key=0, fn=0, DW=8, in_data 0xA5 repeated -> every out_data=0xA5 (zero keystream); frame_done after word 32.
REQ-036 Random key/fn, DW=8 and DW=32 -> out_data matches the bit-exact software model; first in_ready at the REQ-027 cycle.
REQ-037 out_ready held low 50 cycles mid-frame -> in_ready=0 throughout, out_data stable, no keystream bit lost after release.
REQ-038 With A5_FN_AUTOINC_EN, fn=0x3FFFFF -> second frame keyed with fn=0x000000, matching the model.
REQ-039 rst_n low during WARMUP, then start -> outputs reset per REQ-030; the new frame matches a fresh model run.
REQ-040 start pulsed during RUN -> ignored; keystream unchanged.
